window_gen_kxk: RTL
===================

# window_gen_kxk

Parametrised K×K sliding-window generator for the streaming image pipeline, replacing the fixed 3×3 shift-RAM window ahead of the Gaussian, Sobel and NMS stages. Pixels arrive raster-ordered, one per accepted cycle. K−1 inferred line buffers and a K×K register window emit one fully populated window per pixel whose window lies inside the image, tagged with centre coordinates and an end-of-frame marker. Frame sync is explicit, so partial and garbled frames are detected rather than silently misaligned.

## Interface
- DATA_WIDTH, 16: pixel width in bits.
- IMG_WIDTH, 640: pixels per row, ≥ KERNEL_SIZE.
- IMG_HEIGHT, 512: rows per frame, ≥ KERNEL_SIZE.
- KERNEL_SIZE, 3: window edge K; odd, 3..7.
- CW, $clog2(max(IMG_WIDTH,IMG_HEIGHT)): coordinate width, derived.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  pixel strobe; no backpressure.
- in_sof  in  1  qualifies the first pixel of a frame; ignored unless in_valid=1.
- in_data  in  DATA_WIDTH  pixel.
- out_valid  out  1  window strobe, one cycle per window.
- out_window  out  K*K*DATA_WIDTH  window; element (r,c) at [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]. r=0 is the oldest row; c=0 is the oldest column.
- out_row, out_col  out  CW each  centre coordinate of the window.
- out_eof  out  1  high with the last window of a frame.
- busy  out  1  high in ACTIVE state.
- err_sync  out  1  sticky sync error; cleared only by reset.

## Operation
- States:
  - IDLE: in_valid without in_sof is dropped and sets err_sync. in_valid with in_sof is accepted as pixel (0,0) and moves to ACTIVE.
  - ACTIVE: every in_valid is accepted. Column counter x (0..IMG_WIDTH−1) wraps and increments row counter y.
  - On the accepted pixel (IMG_WIDTH−1, IMG_HEIGHT−1), return to IDLE.
- in_sof while ACTIVE: the pixel is accepted as (0,0), err_sync=1, and the state stays ACTIVE. The truncated frame produces no out_eof.
- Line buffers LB[0..K−2], depth IMG_WIDTH, indexed by x. On an accepted pixel:
  - LB[0][x] ← in_data; LB[i][x] ← old LB[i−1][x].
  - Reads of column x return pre-write contents.
  - The column vector {LB[K−2][x] … LB[0][x], in_data} shifts into the window. The oldest column is discarded.
- Line buffers are never cleared. Stale data cannot appear in a window because windows require y ≥ K−1 within the current frame.
- Window emission: for the accepted pixel (x,y) with x ≥ K−1 and y ≥ K−1:
  - out_valid=1 next cycle.
  - Window covers rows y−K+1..y and columns x−K+1..x.
  - out_row = y−(K−1)/2, out_col = x−(K−1)/2.
- Windows per frame: (IMG_WIDTH−K+1)·(IMG_HEIGHT−K+1).
- out_eof=1 together with the window of pixel (IMG_WIDTH−1, IMG_HEIGHT−1).
- Window registers hold between windows. out_row, out_col and out_window are don't-care when out_valid=0, but stable.

## Timing
- Latency: 1 cycle, accepted pixel → out_valid.
- Full throughput: one pixel per cycle. Arbitrary in_valid gaps are allowed; gaps freeze all state.
- Back-to-back frames: the in_sof pixel may arrive the cycle after the last pixel of the previous frame, with no bubble.
- Reset values: out_valid=0, out_eof=0, busy=0, err_sync=0, out_row=0, out_col=0, out_window=0, x=y=0, state IDLE.
- Async reset mid-frame: clears immediately; the next frame needs in_sof.
- Coordinate counters never exceed IMG_WIDTH−1 and IMG_HEIGHT−1.

## Test plan
Common setup unless noted: IMG_WIDTH=8, IMG_HEIGHT=6, K=3, DATA_WIDTH=16, pixel = y*16+x.
- One contiguous frame, in_sof on the first pixel →
  - 24 windows total.
  - First window one cycle after pixel (2,2): out_row=1, out_col=1, elements (0,0)=0x00, (1,1)=0x11, (2,2)=0x22.
  - Last window: out_row=4, out_col=6, (2,2)=0x57, out_eof=1.
  - busy falls with the last pixel.
- Same frame with random 0–3 cycle in_valid gaps → identical window/coordinate sequence to the contiguous case; out_valid never follows an idle cycle.
- Ten pixels without in_sof after reset → no out_valid, err_sync=1, busy=0. A following valid frame still produces 24 correct windows.
- in_sof reasserted at pixel (3,4) of frame 1 → err_sync=1; no out_eof for frame 1; next window at out_row=1, out_col=1 from the new data only.
- K=5, IMG_WIDTH=8, IMG_HEIGHT=6 → 8 windows. First has centre (2,2), element (0,0)=0x00, (4,4)=0x44; last has out_eof=1 with centre (3,5).
- rst_n pulsed low at pixel (5,3) → all outputs zero immediately. The next in_sof frame produces 24 correct windows with no residue from the aborted frame.

Source files
------------

// File: rtl/window_gen_kxk_if.sv
// Pixel-in / window-out stream bundle for window_gen_kxk.
// The master drives pixels and observes windows; the slave is the window generator.
interface window_gen_kxk_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int CW          = 10
);
  logic                                          in_valid;
  logic                                          in_sof;
  logic [DATA_WIDTH-1:0]                         in_data;
  logic                                          out_valid;
  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] out_window;
  logic [CW-1:0]                                 out_row;
  logic [CW-1:0]                                 out_col;
  logic                                          out_eof;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_valid, out_window, out_row, out_col, out_eof
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_valid, out_window, out_row, out_col, out_eof
  );
endinterface

// File: rtl/window_gen_kxk.sv
// K x K sliding-window generator: K-1 line buffers feed a K x K register window,
// emitting one window per in-image pixel with centre coordinates and end-of-frame.
module window_gen_kxk #(
    parameter int DATA_WIDTH  = 16,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 512,
    parameter int KERNEL_SIZE = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    window_gen_kxk_if.slave  bus,
    output logic             busy,
    output logic             err_sync
);

    localparam int unsigned KU   = KERNEL_SIZE;
    localparam int unsigned DW   = DATA_WIDTH;
    localparam int          CW   = $clog2((IMG_WIDTH > IMG_HEIGHT) ? IMG_WIDTH : IMG_HEIGHT);
    localparam int          XW   = $clog2(IMG_WIDTH);
    localparam int          HALF = (KERNEL_SIZE - 1) / 2;

    localparam logic [CW-1:0] X_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] K_LAST = CW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] HALF_C = CW'(HALF);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]          state;
    logic [CW-1:0]       x;
    logic [CW-1:0]       y;
    logic [CW-1:0]       cur_x;
    logic [CW-1:0]       cur_y;
    logic [XW-1:0]       lb_idx;
    logic                accept;
    logic                emit;
    logic                last_px;
    logic                sync_bad;

    logic [DW-1:0]       lb      [KU-1][IMG_WIDTH];
    logic [DW-1:0]       col     [KU];
    logic [DW-1:0]       win     [KU][KU];
    logic [KU*KU*DW-1:0] win_flat;

    // An in_sof pixel is always coordinate (0,0), whatever the counters hold.
    always_comb begin
        accept   = bus.in_valid && (bus.in_sof || (state == ACTIVE));
        sync_bad = bus.in_valid && (bus.in_sof == (state == ACTIVE));
        cur_x    = bus.in_sof ? '0 : x;
        cur_y    = bus.in_sof ? '0 : y;
        lb_idx   = cur_x[XW-1:0];
        last_px  = (cur_x == X_LAST) && (cur_y == Y_LAST);
        emit     = accept && (cur_x >= K_LAST) && (cur_y >= K_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            err_sync <= 1'b0;
        end else begin
            if (sync_bad)
                err_sync <= 1'b1;
            if (accept) begin
                if (last_px) begin
                    state <= IDLE;
                    x     <= '0;
                    y     <= '0;
                end else begin
                    state <= ACTIVE;
                    if (cur_x == X_LAST) begin
                        x <= '0;
                        y <= cur_y + 1'b1;
                    end else begin
                        x <= cur_x + 1'b1;
                        y <= cur_y;
                    end
                end
            end
        end
    end

    assign busy = (state == ACTIVE);

    // Line buffers are never cleared; stale rows cannot reach an emitted window.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][lb_idx] <= bus.in_data;
            for (int unsigned i = 1; i < KU - 1; i++)
                lb[i][lb_idx] <= lb[i-1][lb_idx];
        end
    end

    // Column vector: row 0 is the oldest line, row K-1 is the incoming pixel.
    always_comb begin
        col = '{default: '0};
        for (int unsigned r = 0; r < KU - 1; r++)
            col[r] = lb[KU-2-r][lb_idx];
        col[KU-1] = bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < KU; r++)
                for (int unsigned c = 0; c < KU; c++)
                    win[r][c] <= '0;
        end else if (accept) begin
            for (int unsigned r = 0; r < KU; r++) begin
                for (int unsigned c = 0; c < KU - 1; c++)
                    win[r][c] <= win[r][c+1];
                win[r][KU-1] <= col[r];
            end
        end
    end

    always_comb begin
        win_flat = '0;
        for (int unsigned r = 0; r < KU; r++)
            for (int unsigned c = 0; c < KU; c++)
                win_flat[(r*KU+c)*DW +: DW] = win[r][c];
    end

    assign bus.out_window = win_flat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_eof   <= 1'b0;
            bus.out_row   <= '0;
            bus.out_col   <= '0;
        end else begin
            bus.out_valid <= emit;
            bus.out_eof   <= emit && last_px;
            if (emit) begin
                bus.out_row <= cur_y - HALF_C;
                bus.out_col <= cur_x - HALF_C;
            end
        end
    end

endmodule
